// File: rtl/loudness_peak_tracker_pkg.sv
// Shared types and default sizing for the loudness peak tracker.
package loudness_peak_tracker_pkg;

  localparam int unsigned W_DEF       = 41;
  localparam int unsigned NANGLES_DEF = 360;
  localparam int unsigned AW_DEF      = 9;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

endpackage

// File: rtl/loudness_peak_tracker_angle_sequencer.sv
// Expected-angle counter for one sweep, with match/first/last flags.
module angle_sequencer
  import loudness_peak_tracker_pkg::*;
#(
  parameter int unsigned NAngles = NANGLES_DEF,
  parameter int unsigned AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic [AW-1:0] angle_index,
  output logic          match,
  output logic          first,
  output logic          last
);

  logic [AW-1:0] expected;

  // clear (sweep start/restart) wins over advance in the same cycle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      expected <= '0;
    end else if (advance) begin
      expected <= expected + AW'(1);
    end
  end

  always_comb begin
    match = (angle_index == expected);
    first = (expected == '0);
    last  = (expected == AW'(NAngles - 1));
  end

endmodule

// File: rtl/loudness_peak_tracker.sv
// Tracks peak loudness/angle and above-threshold count over one angular sweep.
module loudness_peak_tracker
  import loudness_peak_tracker_pkg::*;
#(
  parameter int unsigned W       = W_DEF,
  parameter int unsigned NAngles = NANGLES_DEF,
  parameter int unsigned AW      = AW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          loudness_valid,
  input  logic [W-1:0]  loudness,
  input  logic [AW-1:0] angle_index,
  input  logic [W-1:0]  threshold,
  output logic          busy,
  output logic          peak_valid,
  output logic [AW-1:0] peak_angle,
  output logic [W-1:0]  peak_loudness,
  output logic [AW:0]   above_count,
  output logic          seq_error
);

  state_t       state, next_state;
  logic [W-1:0] thr_q;
  logic         restart, scan_sample, accept, reject;
  logic         match, first, last;

  // start is honoured in IDLE and SCAN only; a sample alongside start is dropped
  always_comb begin
    restart     = start && (state != REPORT);
    scan_sample = (state == SCAN) && loudness_valid && !start;
    accept      = scan_sample && match;
    reject      = scan_sample && !match;
  end

  angle_sequencer #(
    .NAngles(NAngles),
    .AW     (AW)
  ) u_seq (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .advance    (accept),
    .angle_index(angle_index),
    .match      (match),
    .first      (first),
    .last       (last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SCAN;
      SCAN: begin
        if (start)              next_state = SCAN;
        else if (accept && last) next_state = REPORT;
      end
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    peak_valid = (state == REPORT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_loudness <= '0;
      peak_angle    <= '0;
      above_count   <= '0;
      seq_error     <= 1'b0;
      thr_q         <= '0;
    end else if (restart) begin
      peak_loudness <= '0;
      peak_angle    <= '0;
      above_count   <= '0;
      seq_error     <= 1'b0;
      thr_q         <= threshold;
    end else begin
      if (accept) begin
        // strict compare keeps the lowest angle on ties; angle 0 always loads
        if (first || (loudness > peak_loudness)) begin
          peak_loudness <= loudness;
          peak_angle    <= angle_index;
        end
        if (loudness > thr_q) begin
          above_count <= above_count + (AW+1)'(1);
        end
      end
      if (reject) begin
        seq_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_loudness_peak_tracker.sv
// Directed bench: sweep results are queued at stimulus time and checked on peak_valid.
module tb_loudness_peak_tracker;

  localparam int unsigned W  = 41;
  localparam int unsigned NA = 360;
  localparam int unsigned AW = 9;

  typedef struct {
    string  tag;
    longint angle;
    longint loud;
    longint cnt;
    longint err;
  } result_t;

  logic          clk = 1'b0;
  logic          reset, start, loudness_valid;
  logic [W-1:0]  loudness, threshold;
  logic [AW-1:0] angle_index;
  logic          busy, peak_valid, seq_error;
  logic [AW-1:0] peak_angle;
  logic [W-1:0]  peak_loudness;
  logic [AW:0]   above_count;

  int      vectors    = 0;
  int      miscompares = 0;
  result_t exp_q[$];

  loudness_peak_tracker #(
    .W      (W),
    .NAngles(NA),
    .AW     (AW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .loudness_valid(loudness_valid),
    .loudness      (loudness),
    .angle_index   (angle_index),
    .threshold     (threshold),
    .busy          (busy),
    .peak_valid    (peak_valid),
    .peak_angle    (peak_angle),
    .peak_loudness (peak_loudness),
    .above_count   (above_count),
    .seq_error     (seq_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Inputs change right after a falling edge; outputs are read at the next falling edge.
  task automatic apply(input logic r, input logic s, input logic v, input int a, input longint l);
    reset          = r;
    start          = s;
    loudness_valid = v;
    angle_index    = AW'(a);
    loudness       = W'(l);
    @(negedge clk);
  endtask

  task automatic push(input string tag, input longint a, input longint l, input longint c,
                      input longint e);
    result_t r;
    r.tag = tag; r.angle = a; r.loud = l; r.cnt = c; r.err = e;
    exp_q.push_back(r);
  endtask

  always @(negedge clk) begin
    if (peak_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_peak_valid", 1, 0);
      end else begin
        result_t r;
        r = exp_q.pop_front();
        check({r.tag, "_angle"}, longint'(peak_angle), r.angle);
        check({r.tag, "_loud"}, longint'(peak_loudness), r.loud);
        check({r.tag, "_count"}, longint'(above_count), r.cnt);
        check({r.tag, "_err"}, longint'(seq_error), r.err);
      end
    end
  end

  initial begin
    threshold = '0;
    apply(1, 0, 0, 0, 0);
    apply(1, 1, 1, 0, 77);
    check("rst_busy", longint'(busy), 0);
    check("rst_pv", longint'(peak_valid), 0);
    check("rst_angle", longint'(peak_angle), 0);
    check("rst_loud", longint'(peak_loudness), 0);
    check("rst_count", longint'(above_count), 0);
    check("rst_err", longint'(seq_error), 0);

    // Ramp sweep with an ignored invalid cycle; also checks report timing.
    threshold = 41'd1000;
    apply(0, 1, 0, 0, 0);
    check("start_busy", longint'(busy), 1);
    threshold = '0;
    for (int a = 0; a < 359; a++) begin
      if (a == 50) apply(0, 0, 0, 7, 99999);
      apply(0, 0, 1, a, a * 10);
    end
    check("pre_last_pv", longint'(peak_valid), 0);
    push("ramp", 359, 3590, 259, 0);
    apply(0, 0, 1, 359, 3590);
    check("t_n1_pv", longint'(peak_valid), 1);
    check("t_n1_busy", longint'(busy), 1);
    apply(0, 1, 0, 0, 0);
    check("t_n2_pv", longint'(peak_valid), 0);
    check("t_n2_busy", longint'(busy), 0);
    apply(0, 0, 1, 0, 12345);
    apply(0, 0, 0, 0, 0);
    check("hold_angle", longint'(peak_angle), 359);
    check("hold_loud", longint'(peak_loudness), 3590);
    check("hold_count", longint'(above_count), 259);

    // Tie at 5000: the lower angle must win.
    threshold = 41'd1000;
    apply(0, 1, 0, 0, 0);
    for (int a = 0; a < 360; a++) begin
      if (a == 359) push("tie", 42, 5000, 2, 0);
      apply(0, 0, 1, a, (a == 42 || a == 200) ? 5000 : 100);
    end
    apply(0, 0, 0, 0, 0);

    // Gap: 11 arrives instead of 10 and is rejected; sweep completes once 10 arrives.
    threshold = 41'd100;
    apply(0, 1, 0, 0, 0);
    for (int a = 0; a < 10; a++) apply(0, 0, 1, a, a);
    apply(0, 0, 1, 11, 11);
    check("gap_err", longint'(seq_error), 1);
    check("gap_busy", longint'(busy), 1);
    for (int a = 10; a < 360; a++) begin
      if (a == 359) push("gap", 359, 359, 259, 1);
      apply(0, 0, 1, a, a);
    end
    apply(0, 0, 0, 0, 0);

    // Mid-sweep reset at angle 180 discards everything.
    threshold = 41'd10;
    apply(0, 1, 0, 0, 0);
    for (int a = 0; a <= 180; a++) apply(0, 0, 1, a, (a == 50) ? 9999 : 20);
    apply(1, 1, 1, 181, 30000);
    check("mrst_busy", longint'(busy), 0);
    check("mrst_loud", longint'(peak_loudness), 0);
    check("mrst_count", longint'(above_count), 0);
    threshold = 41'd600;
    apply(0, 1, 0, 0, 0);
    threshold = '0;
    for (int a = 0; a < 360; a++) begin
      if (a == 359) push("fresh", 77, 800, 1, 0);
      apply(0, 0, 1, a, (a == 77) ? 800 : 500);
    end
    apply(0, 0, 0, 0, 0);

    // start re-pulsed at angle 100 together with an angle-100 sample.
    threshold = 41'd15;
    apply(0, 1, 0, 0, 0);
    for (int a = 0; a < 100; a++) apply(0, 0, 1, a, (a == 50) ? 60000 : 30);
    apply(0, 1, 1, 100, 99999);
    check("restart_busy", longint'(busy), 1);
    check("restart_count", longint'(above_count), 0);
    for (int a = 0; a < 360; a++) begin
      if (a == 359) push("restart", 300, 20, 1, 0);
      apply(0, 0, 1, a, (a == 300) ? 20 : 10);
    end
    apply(0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0);

    check("pending_results", longint'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
